// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between execute and a byte-lane data RAM.
// Aligns stores to lanes, extends loads, splits misaligned accesses in two.
module lsu_mem_ctrl #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-3:0] mem_addr,
    output logic [3:0]               mem_wstrb,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int IW = ADDRESS_WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_ISSUE1,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t                   state_q, state_d;
    logic                     we_q;
    logic                     err_q;
    logic [2:0]               f3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata0_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic                     req_illegal;
    logic                     split;
    logic [3:0]               size_mask;
    logic [1:0]               off;
    logic [IW-1:0]            idx0;
    logic [IW-1:0]            idx1;
    logic [63:0]              st_wide;
    logic [7:0]               st_mask;
    logic [63:0]              ld_pair;
    logic [31:0]              ld_word;
    logic [31:0]              ld_ext;

    assign off     = addr_q[1:0];
    assign idx0    = addr_q[ADDRESS_WIDTH-1:2];
    assign idx1    = idx0 + IW'(1);
    assign st_wide = {32'b0, wdata_q} << {off, 3'b000};
    assign st_mask = {4'b0000, size_mask} << off;
    assign ld_pair = split ? {mem_rdata, rdata0_q} : {32'b0, mem_rdata};
    assign ld_word = 32'(ld_pair >> {off, 3'b000});

    assign resp_rdata = rdata_q;
    assign resp_err   = resp_valid & err_q;

    // Reject unknown widths and unsigned-store encodings at accept time
    always_comb begin
        req_illegal = 1'b0;
        unique case (req_funct3)
            3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
            3'b100, 3'b101:         req_illegal = req_we;
            default:                req_illegal = 1'b0;
        endcase
    end

    // Byte-lane mask for the access size and whether it crosses a word
    always_comb begin
        size_mask = 4'b1111;
        split     = 1'b0;
        unique case (f3_q[1:0])
            2'b00: begin
                size_mask = 4'b0001;
                split     = 1'b0;
            end
            2'b01: begin
                size_mask = 4'b0011;
                split     = (off == 2'b11);
            end
            default: begin
                size_mask = 4'b1111;
                split     = (off != 2'b00);
            end
        endcase
    end

    // Sign or zero extension of the shifted load word
    always_comb begin
        ld_ext = ld_word;
        unique case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Request latch, first split read word and final response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (req_valid && req_ready) begin
                we_q    <= req_we;
                err_q   <= req_illegal;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
            end
            if (state_q == S_ISSUE1 && !we_q) rdata0_q <= mem_rdata;
            if (state_q == S_CAPTURE)         rdata_q  <= ld_ext;
        end
    end

    // Next state and the combinational RAM/handshake outputs
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wstrb  = 4'b0000;
        mem_wdata  = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_illegal ? S_RESP : S_ISSUE0;
            end
            S_ISSUE0: begin
                mem_en   = 1'b1;
                mem_we   = we_q;
                mem_addr = idx0;
                if (we_q) begin
                    mem_wstrb = st_mask[3:0];
                    mem_wdata = st_wide[31:0];
                end
                if (split)     state_d = S_ISSUE1;
                else if (we_q) state_d = S_RESP;
                else           state_d = S_CAPTURE;
            end
            S_ISSUE1: begin
                mem_en   = 1'b1;
                mem_we   = we_q;
                mem_addr = idx1;
                if (we_q) begin
                    mem_wstrb = st_mask[7:4];
                    mem_wdata = st_wide[63:32];
                end
                state_d = we_q ? S_RESP : S_CAPTURE;
            end
            S_CAPTURE: state_d = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and random loads/stores against a byte-array
// memory model; RAM behind the DUT is a simple registered-read word array.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] ram [1024];
    logic [7:0]  refmem [4096];

    int          n_chk = 0;
    int          n_fail = 0;

    logic [9:0]  acc_idx [4];
    logic        acc_we [4];
    logic [3:0]  acc_strb [4];
    logic [31:0] acc_wd [4];
    int          n_acc;

    lsu_mem_ctrl #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    // Data RAM: byte-lane writes, read data one cycle after access
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) ram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic ref_init();
        logic [31:0] w;
        for (int a = 0; a < 4096; a++) begin
            w = init_word(a >> 2);
            refmem[a] = w[8*(a%4)+:8];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request through the DUT, checked against the byte-level model
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        int          size, exp_lat, exp_nacc, lat;
        logic        ill, spl, seen, err;
        logic [31:0] v, exp_rd, ed, wmask;
        logic [11:0] ba;
        logic [9:0]  ei;
        logic [3:0]  es;
        ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
               (we && f3[2]);
        size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        spl  = (int'(addr[1:0]) + size) > 4;
        exp_lat  = ill ? 1 : (we ? (spl ? 3 : 2) : (spl ? 4 : 3));
        exp_nacc = ill ? 0 : (spl ? 2 : 1);
        v = 32'h0;
        for (int i = 0; i < size; i++) begin
            ba = addr + 12'(i);
            v  = v | (32'(refmem[ba]) << (8 * i));
        end
        if (!f3[2] && size < 4 && v[8*size-1])
            v = v | ~((32'h1 << (8 * size)) - 32'h1);
        exp_rd = (ill || we) ? 32'h0 : v;

        chk("ready_idle", {31'b0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = 12'($urandom);
        req_wdata  = $urandom;

        n_acc = 0;
        seen  = 1'b0;
        lat   = 0;
        err   = 1'b0;
        rd    = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_en) begin
                if (n_acc < 4) begin
                    acc_idx[n_acc]  = mem_addr;
                    acc_we[n_acc]   = mem_we;
                    acc_strb[n_acc] = mem_wstrb;
                    acc_wd[n_acc]   = mem_wdata;
                end
                n_acc++;
            end
            chk("ready_busy", {31'b0, req_ready}, 32'h0);
            if (resp_valid) begin
                seen = 1'b1;
                lat  = c;
                err  = resp_err;
                rd   = resp_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        chk("resp_seen", {31'b0, seen}, 32'h1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("resp_err", {31'b0, err}, {31'b0, ill});
        chk("resp_rdata", rd, exp_rd);
        chk("n_access", 32'(n_acc), 32'(exp_nacc));
        for (int k = 0; k < exp_nacc && k < n_acc; k++) begin
            ei = addr[11:2] + 10'(k);
            chk("mem_addr", 32'(acc_idx[k]), 32'(ei));
            chk("mem_we", {31'b0, acc_we[k]}, {31'b0, we});
            if (we) begin
                es    = 4'b0;
                ed    = 32'h0;
                wmask = 32'h0;
                for (int i = 0; i < size; i++) begin
                    ba = addr + 12'(i);
                    if (ba[11:2] == ei) begin
                        es[ba[1:0]]           = 1'b1;
                        ed[8*ba[1:0]+:8]      = wd[8*i+:8];
                        wmask[8*ba[1:0]+:8]   = 8'hFF;
                    end
                end
                chk("mem_wstrb", 32'(acc_strb[k]), 32'(es));
                chk("mem_wdata", acc_wd[k] & wmask, ed);
            end
        end
        if (we && !ill)
            for (int i = 0; i < size; i++) begin
                ba = addr + 12'(i);
                refmem[ba] = wd[8*i+:8];
            end
        @(posedge clk); #1;
        chk("resp_pulse", {31'b0, resp_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] w;
        logic [11:0] a;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 12'h0;
        req_wdata  = 32'h0;
        ref_init();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 3'b010, 12'h010, 32'hDEADBEEF, r);
        chk("sw_idx", 32'(acc_idx[0]), 32'h4);
        chk("sw_strb", 32'(acc_strb[0]), 32'hF);
        chk("sw_wdata", acc_wd[0], 32'hDEADBEEF);

        do_req(1'b1, 3'b010, 12'h010, 32'h80FF1234, r);
        do_req(1'b0, 3'b000, 12'h013, 32'h0, r);
        chk("lb_neg", r, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 12'h013, 32'h0, r);
        chk("lbu", r, 32'h00000080);
        do_req(1'b0, 3'b001, 12'h012, 32'h0, r);
        chk("lh_neg", r, 32'hFFFF80FF);

        do_req(1'b1, 3'b010, 12'h011, 32'h11223344, r);
        chk("ssw_idx0", 32'(acc_idx[0]), 32'h4);
        chk("ssw_strb0", 32'(acc_strb[0]), 32'hE);
        chk("ssw_wd0", acc_wd[0], 32'h22334400);
        chk("ssw_idx1", 32'(acc_idx[1]), 32'h5);
        chk("ssw_strb1", 32'(acc_strb[1]), 32'h1);
        chk("ssw_wd1", acc_wd[1], 32'h00000011);

        do_req(1'b1, 3'b010, 12'h010, 32'hAB000000, r);
        do_req(1'b1, 3'b010, 12'h014, 32'h000000CD, r);
        do_req(1'b0, 3'b001, 12'h013, 32'h0, r);
        chk("slh", r, 32'hFFFFCDAB);
        do_req(1'b0, 3'b101, 12'h013, 32'h0, r);
        chk("slhu", r, 32'h0000CDAB);

        do_req(1'b0, 3'b010, 12'hFFE, 32'h0, r);
        chk("wrap_idx0", 32'(acc_idx[0]), 32'h3FF);
        chk("wrap_idx1", 32'(acc_idx[1]), 32'h000);

        do_req(1'b0, 3'b011, 12'h020, 32'h0, r);
        chk("ill_rdata", r, 32'h0);
        do_req(1'b1, 3'b100, 12'h020, 32'h12345678, r);
        do_req(1'b1, 3'b111, 12'h021, 32'h12345678, r);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom % 2 == 0) ? 12'($urandom % 64)
                                    : 12'(12'hFC0 + ($urandom % 64));
            do_req(1'($urandom), 3'($urandom), a, $urandom, r);
        end

        for (int k = 0; k < 1024; k++) begin
            if (k < 16 || k >= 1008) begin
                w = {refmem[4*k+3], refmem[4*k+2], refmem[4*k+1], refmem[4*k]};
                chk("ram_word", ram[k], w);
            end
        end

        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 12'h011;
        req_wdata  = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_issue0", {31'b0, mem_en}, 32'h1);
        @(posedge clk); #1;
        chk("abort_issue1", {31'b0, mem_en}, 32'h1);
        chk("abort_idx1", 32'(mem_addr), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_en", {31'b0, mem_en}, 32'h0);
        chk("abort_wstrb", 32'(mem_wstrb), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        rst_n = 1'b1;
        ref_init();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("post_rst_resp", {31'b0, resp_valid}, 32'h0);
            chk("post_rst_mem_en", {31'b0, mem_en}, 32'h0);
        end
        do_req(1'b0, 3'b010, 12'h010, 32'h0, r);
        do_req(1'b0, 3'b001, 12'h013, 32'h0, r);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
